// File: rtl/conv_row_packer.sv
// Packs per-pixel convolution results into row words and writes them to the output SRAM via a small FIFO.
// Optional end-of-frame marker write is enabled with `define CONV_PACKER_TERMINATOR_EN.
module conv_row_packer #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned COL_W      = 4,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic              pix_bit,
  input  logic [COL_W-1:0]  pix_col,
  input  logic [ADDR_W-1:0] pix_waddr,
  input  logic              pix_last,
  input  logic              frame_end,
  input  logic              wr_stall,
  output logic              dut_sram_write_enable,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

`ifdef CONV_PACKER_TERMINATOR_EN
  typedef enum logic [2:0] {IDLE, PACK, DRAIN, TERM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, PACK, DRAIN, DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pack_q, pack_c;
  logic [ADDR_W-1:0] row_addr_q, row_addr_c;
  logic              commit_pend_q;
  entry_t            mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              fifo_full, fifo_nonempty;
  logic              accept, push, pop, pend_set, pend_clr;
  entry_t            push_entry, head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_nonempty = (count_q != '0);
  assign pix_ready     = !fifo_full && ((state_q == IDLE) || (state_q == PACK));
  assign accept        = pix_valid && pix_ready;
  assign pop           = fifo_nonempty && !wr_stall;
  assign head          = mem_q[rd_ptr_q];
  assign busy          = (state_q != IDLE) || fifo_nonempty;
  assign frame_done    = (state_q == DONE);

  // Row word as it would look after this cycle's pixel; the address latches on the row's first pixel.
  always_comb begin
    pack_c = pack_q;
    if (accept) pack_c[pix_col] = pix_bit;
    row_addr_c = (state_q == IDLE) ? pix_waddr : row_addr_q;
    push_entry = '{addr: row_addr_c, data: pack_c};
  end

  // Next-state and FIFO push decisions.
  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) push = pix_last;
        if (frame_end) begin
          if (accept && !pix_last) push = 1'b1;
          state_d = DRAIN;
        end else if (accept && !pix_last) begin
          state_d = PACK;
        end
      end
      PACK: begin
        if (frame_end) begin
          if (accept || !fifo_full) push = 1'b1;
          else                      pend_set = 1'b1;
          state_d = DRAIN;
        end else if (accept && pix_last) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (commit_pend_q) begin
          if (!fifo_full) begin
            push     = 1'b1;
            pend_clr = 1'b1;
          end
        end else if (!fifo_nonempty) begin
`ifdef CONV_PACKER_TERMINATOR_EN
          state_d = TERM;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef CONV_PACKER_TERMINATOR_EN
      TERM: begin
        if (!wr_stall) state_d = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      state_q       <= IDLE;
      pack_q        <= '0;
      row_addr_q    <= '0;
      commit_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push)        pack_q <= '0;
      else if (accept) pack_q <= pack_c;
      if (accept && (state_q == IDLE)) row_addr_q <= pix_waddr;
      if (pend_set)      commit_pend_q <= 1'b1;
      else if (pend_clr) commit_pend_q <= 1'b0;
    end
  end

  // Row FIFO; a same-cycle pop never makes room for the push.
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

`ifdef CONV_PACKER_TERMINATOR_EN
  logic [ADDR_W-1:0] last_addr_q;
  logic              wrote_any_q;
  logic [ADDR_W-1:0] marker_addr;

  // Track the last written row so the marker lands just past it.
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      last_addr_q <= '0;
      wrote_any_q <= 1'b0;
    end else if (pop) begin
      last_addr_q <= head.addr;
      wrote_any_q <= 1'b1;
    end else if (state_q == DONE) begin
      wrote_any_q <= 1'b0;
    end
  end

  assign marker_addr            = wrote_any_q ? last_addr_q + ADDR_W'(1) : '0;
  assign dut_sram_write_enable  = pop || ((state_q == TERM) && !wr_stall);
  assign dut_sram_write_address = (state_q == TERM) ? marker_addr : head.addr;
  assign dut_sram_write_data    = (state_q == TERM) ? DATA_W'(16'h00FF) : head.data;
`else
  assign dut_sram_write_enable  = pop;
  assign dut_sram_write_address = head.addr;
  assign dut_sram_write_data    = head.data;
`endif

endmodule

// File: tb/tb_conv_row_packer.sv
// Directed bench for conv_row_packer: table of single-row vectors plus stall, flush, marker, reset and overwrite sequences.
module tb_conv_row_packer;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        pix_valid, pix_ready, pix_bit, pix_last, frame_end, wr_stall;
  logic [3:0]  pix_col;
  logic [11:0] pix_waddr;
  logic        dut_sram_write_enable, busy, frame_done;
  logic [11:0] dut_sram_write_address;
  logic [15:0] dut_sram_write_data;

  int checks = 0;
  int errors = 0;
  logic [27:0] wq [$];

  typedef struct {
    logic [15:0] pattern;
    int          ncols;
    logic [11:0] addr;
    logic [15:0] exp_data;
  } row_vec_t;

  conv_row_packer dut (
    .clk                    (clk),
    .reset_b                (reset_b),
    .pix_valid              (pix_valid),
    .pix_ready              (pix_ready),
    .pix_bit                (pix_bit),
    .pix_col                (pix_col),
    .pix_waddr              (pix_waddr),
    .pix_last               (pix_last),
    .frame_end              (frame_end),
    .wr_stall               (wr_stall),
    .dut_sram_write_enable  (dut_sram_write_enable),
    .dut_sram_write_address (dut_sram_write_address),
    .dut_sram_write_data    (dut_sram_write_data),
    .busy                   (busy),
    .frame_done             (frame_done)
  );

  always #5 clk = ~clk;

  // Record every SRAM write seen at a clock edge.
  always @(posedge clk) begin
    if (dut_sram_write_enable) wq.push_back({dut_sram_write_address, dut_sram_write_data});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input logic b, input logic [3:0] c, input logic [11:0] a, input logic l);
    int n = 0;
    pix_valid = 1'b1;
    pix_bit   = b;
    pix_col   = c;
    pix_waddr = a;
    pix_last  = l;
    #1;
    while (!pix_ready && n < 50) begin
      tick();
      n++;
    end
    if (!pix_ready) check("pix_ready_timeout", 32'(pix_ready), 32'd1);
    tick();
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  // Later pixels carry a different address, which must be ignored.
  task automatic send_row(input logic [15:0] pattern, input int ncols, input logic [11:0] addr, input logic last);
    for (int c = 0; c < ncols; c++)
      send_pix(pattern[c], 4'(c), (c == 0) ? addr : ~addr, last && (c == ncols - 1));
  endtask

  task automatic pulse_frame_end();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  task automatic wait_frame_done(input string tag);
    int  n    = 0;
    bit  seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (frame_done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    tick();
    check({tag, "_done_one_cycle"}, 32'(frame_done), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic check_write(input string name, input int idx, input logic [11:0] a, input logic [15:0] d);
    logic [27:0] e;
    e = (idx < wq.size()) ? wq[idx] : 28'hxxxxxxx;
    check({name, "_addr"}, 32'(e[27:16]), 32'(a));
    check({name, "_data"}, 32'(e[15:0]), 32'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row_vec_t vecs [6];
    vecs[0] = '{16'h5555, 14, 12'h010, 16'h1555};
    vecs[1] = '{16'hFFFF, 16, 12'h011, 16'hFFFF};
    vecs[2] = '{16'h000B, 4,  12'h012, 16'h000B};
    vecs[3] = '{16'h0001, 1,  12'h013, 16'h0001};
    vecs[4] = '{16'hA5C3, 8,  12'hABC, 16'h00C3};
    vecs[5] = '{16'h0000, 16, 12'hFFF, 16'h0000};

    reset_b = 1'b1; pix_valid = 1'b0; pix_bit = 1'b0; pix_col = '0; pix_waddr = '0;
    pix_last = 1'b0; frame_end = 1'b0; wr_stall = 1'b0;
    #2;
    check("rst_pix_ready", 32'(pix_ready), 32'd1);
    check("rst_we", 32'(dut_sram_write_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_addr", 32'(dut_sram_write_address), 32'd0);
    check("rst_data", 32'(dut_sram_write_data), 32'd0);
    repeat (3) tick();
    reset_b = 1'b0;
    tick();

    // Single complete rows: written the cycle after pix_last.
    for (int i = 0; i < 6; i++) begin
      wq.delete();
      send_row(vecs[i].pattern, vecs[i].ncols, vecs[i].addr, 1'b1);
      check($sformatf("row%0d_we", i), 32'(dut_sram_write_enable), 32'd1);
      check($sformatf("row%0d_addr", i), 32'(dut_sram_write_address), 32'(vecs[i].addr));
      check($sformatf("row%0d_data", i), 32'(dut_sram_write_data), 32'(vecs[i].exp_data));
      tick();
      check($sformatf("row%0d_nwrites", i), 32'(wq.size()), 32'd1);
      check($sformatf("row%0d_idle", i), 32'(busy), 32'd0);
    end

    // Stalled write port: FIFO fills after two rows, then drains in order.
    wq.delete();
    wr_stall = 1'b1;
    for (int k = 1; k <= 2; k++) send_row({14'b0, 1'(k & 1), 1'b1}, 2, 12'h100 + 12'(k), 1'b1);
    check("stall_ready_low", 32'(pix_ready), 32'd0);
    repeat (3) tick();
    check("stall_we_low", 32'(dut_sram_write_enable), 32'd0);
    check("stall_addr_hold", 32'(dut_sram_write_address), 32'h101);
    check("stall_data_hold", 32'(dut_sram_write_data), 32'h3);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_no_write", 32'(wq.size()), 32'd0);
    wr_stall = 1'b0;
    for (int k = 3; k <= 5; k++) send_row({14'b0, 1'(k & 1), 1'b1}, 2, 12'h100 + 12'(k), 1'b1);
    repeat (6) tick();
    check("stall_nwrites", 32'(wq.size()), 32'd5);
    for (int k = 1; k <= 5; k++)
      check_write($sformatf("stall_w%0d", k), k - 1, 12'h100 + 12'(k), (k & 1) ? 16'h0003 : 16'h0001);

    // Partial row flushed by frame_end.
    wq.delete();
    send_row(16'h003F, 6, 12'h020, 1'b0);
    check("flush_busy_pack", 32'(busy), 32'd1);
    pulse_frame_end();
    check("flush_ready_drain", 32'(pix_ready), 32'd0);
    check("flush_we", 32'(dut_sram_write_enable), 32'd1);
    check("flush_addr", 32'(dut_sram_write_address), 32'h020);
    check("flush_data", 32'(dut_sram_write_data), 32'h003F);
    wait_frame_done("flush");
    check_write("flush_w0", 0, 12'h020, 16'h003F);
`ifdef CONV_PACKER_TERMINATOR_EN
    check("flush_nwrites", 32'(wq.size()), 32'd2);
    check_write("flush_marker", 1, 12'h021, 16'h00FF);
`else
    check("flush_nwrites", 32'(wq.size()), 32'd1);
`endif

    // Complete last row then frame_end: optional marker one past it.
    wq.delete();
    send_row(16'h1234, 16, 12'h02F, 1'b1);
    pulse_frame_end();
    wait_frame_done("term");
    check_write("term_w0", 0, 12'h02F, 16'h1234);
`ifdef CONV_PACKER_TERMINATOR_EN
    check("term_nwrites", 32'(wq.size()), 32'd2);
    check_write("term_marker", 1, 12'h030, 16'h00FF);
`else
    check("term_nwrites", 32'(wq.size()), 32'd1);
`endif

    // Repeated column overwrites earlier bit.
    wq.delete();
    send_pix(1'b1, 4'd3, 12'h077, 1'b0);
    send_pix(1'b1, 4'd0, 12'h000, 1'b0);
    send_pix(1'b0, 4'd3, 12'h000, 1'b0);
    send_pix(1'b1, 4'd1, 12'h000, 1'b1);
    check("ovw_we", 32'(dut_sram_write_enable), 32'd1);
    check("ovw_addr", 32'(dut_sram_write_address), 32'h077);
    check("ovw_data", 32'(dut_sram_write_data), 32'h0003);
    tick();

    // Reset while a word is buffered: enable drops at once, nothing written afterwards.
    wq.delete();
    wr_stall = 1'b1;
    send_row(16'h0005, 3, 12'h055, 1'b1);
    check("rstmid_buffered", 32'(busy), 32'd1);
    wr_stall = 1'b0;
    #1;
    check("rstmid_we_before", 32'(dut_sram_write_enable), 32'd1);
    reset_b = 1'b1;
    #1;
    check("rstmid_we_async", 32'(dut_sram_write_enable), 32'd0);
    check("rstmid_ready", 32'(pix_ready), 32'd1);
    check("rstmid_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    reset_b = 1'b0;
    repeat (5) tick();
    check("rstmid_no_write", 32'(wq.size()), 32'd0);
    check("rstmid_busy_after", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
